// File: rtl/alu_control_md_if.sv
// EX-stage bus between the pipeline and alu_control_md: decode inputs, ALU select,
// mult/div result path, interlock and architectural HI/LO.
interface alu_control_md_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned SEL_W   = 4
) ();
  logic               valid;
  logic [ALUOP_W-1:0] alu_op;
  logic [5:0]         funct;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SEL_W-1:0]   alu_sel;
  logic               res_src;
  logic [WIDTH-1:0]   md_result;
  logic               md_busy;
  logic               stall;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output valid, alu_op, funct, op_a, op_b,
    input  alu_sel, res_src, md_result, md_busy, stall, hi, lo
  );

  modport slave (
    input  valid, alu_op, funct, op_a, op_b,
    output alu_sel, res_src, md_result, md_busy, stall, hi, lo
  );
endinterface

// File: rtl/alu_control_md.sv
// EX-stage ALU control: alu_op/funct decode plus an iterative multiply/divide unit
// (shift-add multiply, restoring divide) owning HI/LO and the mult/div stall interlock.
module alu_control_md #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned SEL_W   = 4
) (
  input logic              clk,
  input logic              rst,
  alu_control_md_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [0:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_q, rem_neg_q, div_zero_q;

  logic is_rtype, is_mult, is_div, is_md, is_mf, is_mt, md_busy, accept;
  logic sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_rtype = (bus.alu_op == ALUOP_W'(3'b010));
  assign is_mult  = is_rtype & ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
  assign is_div   = is_rtype & ((bus.funct == F_DIV) | (bus.funct == F_DIVU));
  assign is_md    = is_mult | is_div;
  assign is_mf    = is_rtype & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO));
  assign is_mt    = is_rtype & ((bus.funct == F_MTHI) | (bus.funct == F_MTLO));
  assign md_busy  = (state_q == BUSY);
  assign accept   = bus.valid & is_md & ~md_busy;

  // funct[0] clear marks the signed variants (mult, div).
  assign sa    = ~bus.funct[0] & bus.op_a[WIDTH-1];
  assign sb    = ~bus.funct[0] & bus.op_b[WIDTH-1];
  assign a_mag = sa ? -bus.op_a : bus.op_a;
  assign b_mag = sb ? -bus.op_b : bus.op_b;

  always_comb begin
    bus.alu_sel = SEL_W'(4'b0000);
    case (bus.alu_op)
      ALUOP_W'(3'b000): bus.alu_sel = SEL_W'(4'b0010);
      ALUOP_W'(3'b001): bus.alu_sel = SEL_W'(4'b0001);
      ALUOP_W'(3'b011): bus.alu_sel = SEL_W'(4'b0000);
      ALUOP_W'(3'b110): bus.alu_sel = SEL_W'(4'b0110);
      ALUOP_W'(3'b111): bus.alu_sel = SEL_W'(4'b0111);
      ALUOP_W'(3'b010): begin
        case (bus.funct)
          6'b100000: bus.alu_sel = SEL_W'(4'b0010);
          6'b100010: bus.alu_sel = SEL_W'(4'b0110);
          6'b100101: bus.alu_sel = SEL_W'(4'b0001);
          6'b100100: bus.alu_sel = SEL_W'(4'b0000);
          6'b101010: bus.alu_sel = SEL_W'(4'b0111);
          6'b100111: bus.alu_sel = SEL_W'(4'b1100);
          6'b100110: bus.alu_sel = SEL_W'(4'b0011);
          default:   bus.alu_sel = SEL_W'(4'b0000);
        endcase
      end
      default: bus.alu_sel = SEL_W'(4'b0000);
    endcase
  end

  // One iteration of each algorithm; acc_q holds {hi part, lo part}.
  logic [WIDTH:0]     msum, dshift, ddiff;
  logic               qbit;
  logic [WIDTH-1:0]   drem;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   quot, rem, fin_hi, fin_lo;

  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    dshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ddiff  = dshift - {1'b0, opnd_q};
    qbit   = ~ddiff[WIDTH];
    drem   = qbit ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
    step   = is_div_q ? {drem, acc_q[WIDTH-2:0], qbit} : {msum, acc_q[WIDTH-1:1]};
    prod   = neg_q ? -step : step;
    quot   = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem    = rem_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (div_zero_q) begin
      fin_hi = opnd_q;
      fin_lo = '1;
    end else begin
      fin_hi = rem;
      fin_lo = quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_q    <= BUSY;
        cnt_q      <= '0;
        acc_q      <= {{WIDTH{1'b0}}, a_mag};
        is_div_q   <= is_div;
        neg_q      <= sa ^ sb;
        rem_neg_q  <= sa;
        div_zero_q <= is_div & (bus.op_b == '0);
        // A zero divisor makes the iterations irrelevant; keep raw op_a for hi instead.
        opnd_q     <= (is_div & (bus.op_b == '0)) ? bus.op_a : b_mag;
      end else if (bus.valid & is_mt) begin
        if (bus.funct[1]) lo_q <= bus.op_a;
        else              hi_q <= bus.op_a;
      end
    end else begin
      acc_q <= step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        hi_q    <= fin_hi;
        lo_q    <= fin_lo;
        state_q <= IDLE;
      end
    end
  end

  assign bus.res_src   = is_mf;
  assign bus.md_result = is_mf ? (bus.funct[1] ? lo_q : hi_q) : '0;
  assign bus.md_busy   = md_busy;
  assign bus.stall     = bus.valid & md_busy & (is_md | is_mf | is_mt);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
